epw22_issue_ctrl: RTL and testbench

Issue controller that shares the single EPW22 ALU between two requesters. It arbitrates between them round-robin, allocates a tag per command, and sequences the ALU pin protocol: opcode plus operand A in the first cycle, operand B in the second. Returned results are routed to the owning requester by tag. It sits between the stimulus/core side and the ALU pins (data/tag/op in; result/rtag/valid/ready/error out).

---
 rtl/epw22_issue_ctrl_pkg.sv | 23 ++
 rtl/epw22_tag_pool.sv | 99 +++++++++
 rtl/epw22_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_epw22_issue_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epw22_issue_ctrl_pkg.sv
// epw22_issue_ctrl_pkg
//   Shared definitions for the EPW22 ALU issue controller.
//   - Default widths for opcode, operand, result and tag fields.
//   - Issue sequencer state encoding.
//   - A small helper that turns a one-bit requester id into a 2-bit one-hot mask.
package epw22_issue_ctrl_pkg;

  localparam int op_width     = 4;
  localparam int data_width   = 16;
  localparam int result_width = 32;
  localparam int tag_width    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DATA = 2'd2
  } issue_state_t;

  function automatic logic [1:0] req_onehot(input logic req_id);
    return req_id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/epw22_tag_pool.sv
// epw22_tag_pool
//   Tag bookkeeping for the issue controller.
//   Ports:
//     clk_i, rst_ni      clock and asynchronous active-low reset
//     alloc_i            allocate the lowest free tag this cycle
//     alloc_owner_i      requester id recorded against the allocated tag
//     free_i             a result returned on free_tag_i this cycle
//     free_tag_i         tag of the returned result
//     alloc_tag_o        lowest free tag, taken from the registered free map
//     avail_o            at least one tag is free
//     owner_o            requester that owns free_tag_i
//     hit_o              free_i names an allocated tag (result is routable)
//     outstanding_o      number of allocated tags
//     proto_err_o        sticky: a result came back on an unallocated tag
module epw22_tag_pool
  import epw22_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = tag_width
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic             alloc_owner_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic [TAG_W-1:0] alloc_tag_o,
  output logic             avail_o,
  output logic             owner_o,
  output logic             hit_o,
  output logic [TAG_W:0]   outstanding_o,
  output logic             proto_err_o
);

  localparam int NTAGS = 2 ** TAG_W;
  localparam logic [TAG_W:0] CntOne = (TAG_W + 1)'(1);

  logic [NTAGS-1:0] free_q, free_d;
  logic [NTAGS-1:0] owner_q, owner_d;
  logic [TAG_W:0]   outstanding_q, outstanding_d;
  logic             proto_err_q, proto_err_d;
  logic             do_alloc;
  logic             miss;

  // Scan from the top down so the last assignment wins: lowest free index.
  always_comb begin
    alloc_tag_o = '0;
    avail_o     = 1'b0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_tag_o = TAG_W'(i);
        avail_o     = 1'b1;
      end
    end
  end

  assign do_alloc = alloc_i & avail_o;
  assign hit_o    = free_i & ~free_q[free_tag_i];
  assign miss     = free_i &  free_q[free_tag_i];
  assign owner_o  = owner_q[free_tag_i];

  // An allocated tag can never be the lowest free one, so a simultaneous
  // free and allocate always touch different bits of the map.
  always_comb begin
    free_d        = free_q;
    owner_d       = owner_q;
    outstanding_d = outstanding_q;
    proto_err_d   = proto_err_q | miss;
    if (hit_o) begin
      free_d[free_tag_i] = 1'b1;
    end
    if (do_alloc) begin
      free_d[alloc_tag_o]  = 1'b0;
      owner_d[alloc_tag_o] = alloc_owner_i;
    end
    case ({do_alloc, hit_o})
      2'b10:   outstanding_d = outstanding_q + CntOne;
      2'b01:   outstanding_d = outstanding_q - CntOne;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q        <= '1;
      owner_q       <= '0;
      outstanding_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      free_q        <= free_d;
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign proto_err_o   = proto_err_q;

endmodule

// File: rtl/epw22_issue_ctrl.sv
// epw22_issue_ctrl
//   Shares one EPW22 ALU between two requesters. Round-robin arbitration,
//   one tag per command, two-cycle ALU pin sequence (opcode + A, then B),
//   and tag-based routing of returned results back to their owner.
//   Ports:
//     clk, reset                 clock and asynchronous active-low reset
//     rq_valid/rq_ready          per-requester command handshake (bit i = requester i)
//     rq_op, rq_a, rq_b          packed per-requester opcode and operands
//     alu_ready                  ALU can take a new command (looked at in IDLE only)
//     alu_start/op/data/tag      ALU command pins; alu_start qualifies op and tag
//     alu_valid/result/rtag/error  ALU result pins
//     rs_valid/result/tag/error  routed response, one cycle after alu_valid
//     outstanding                number of allocated tags
//     proto_err                  sticky: result on an unallocated tag
module epw22_issue_ctrl
  import epw22_issue_ctrl_pkg::*;
#(
  parameter int OP_W   = op_width,
  parameter int DATA_W = data_width,
  parameter int RES_W  = result_width,
  parameter int TAG_W  = tag_width
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [2*OP_W-1:0]   rq_op,
  input  logic [2*DATA_W-1:0] rq_a,
  input  logic [2*DATA_W-1:0] rq_b,
  input  logic                alu_ready,
  output logic                alu_start,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_data,
  output logic [TAG_W-1:0]    alu_tag,
  input  logic                alu_valid,
  input  logic [RES_W-1:0]    alu_result,
  input  logic [TAG_W-1:0]    alu_rtag,
  input  logic                alu_error,
  output logic [1:0]          rs_valid,
  output logic [RES_W-1:0]    rs_result,
  output logic [TAG_W-1:0]    rs_tag,
  output logic                rs_error,
  output logic [TAG_W:0]      outstanding,
  output logic                proto_err
);

  issue_state_t state_q, state_d;

  logic              rr_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_data_q;
  logic [DATA_W-1:0] b_q;
  logic [TAG_W-1:0]  alu_tag_q;
  logic [1:0]        rs_valid_q;
  logic [RES_W-1:0]  rs_result_q;
  logic [TAG_W-1:0]  rs_tag_q;
  logic              rs_error_q;

  logic              winner;
  logic              grant;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]  alloc_tag;
  logic              avail;
  logic              owner;
  logic              hit;

  // With both requesters asking, the pointer decides; with one asking,
  // bit 1 alone names requester 1 and otherwise requester 0 is the one.
  always_comb begin
    if (rq_valid == 2'b11) begin
      winner = rr_q;
    end else begin
      winner = rq_valid[1];
    end
  end

  assign grant  = (state_q == IDLE) && (rq_valid != 2'b00) && avail && alu_ready;
  assign sel_op = winner ? rq_op[2*OP_W-1:OP_W]     : rq_op[OP_W-1:0];
  assign sel_a  = winner ? rq_a[2*DATA_W-1:DATA_W]  : rq_a[DATA_W-1:0];
  assign sel_b  = winner ? rq_b[2*DATA_W-1:DATA_W]  : rq_b[DATA_W-1:0];

  // rq_ready is combinational, so it is also forced low while reset is held.
  assign rq_ready = (grant && reset) ? req_onehot(winner) : 2'b00;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = OP;
      OP:      state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  epw22_tag_pool #(
    .TAG_W(TAG_W)
  ) u_tag_pool (
    .clk_i         (clk),
    .rst_ni        (reset),
    .alloc_i       (grant),
    .alloc_owner_i (winner),
    .free_i        (alu_valid),
    .free_tag_i    (alu_rtag),
    .alloc_tag_o   (alloc_tag),
    .avail_o       (avail),
    .owner_o       (owner),
    .hit_o         (hit),
    .outstanding_o (outstanding),
    .proto_err_o   (proto_err)
  );

  // alu_data carries A from the grant onward, switches to B for the DATA
  // cycle and then simply holds; alu_start is the only qualifier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      alu_op_q    <= '0;
      alu_data_q  <= '0;
      b_q         <= '0;
      alu_tag_q   <= '0;
      rs_valid_q  <= 2'b00;
      rs_result_q <= '0;
      rs_tag_q    <= '0;
      rs_error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        alu_op_q   <= sel_op;
        alu_data_q <= sel_a;
        b_q        <= sel_b;
        alu_tag_q  <= alloc_tag;
        rr_q       <= ~winner;
      end else if (state_q == OP) begin
        alu_data_q <= b_q;
      end
      rs_valid_q <= hit ? req_onehot(owner) : 2'b00;
      if (hit) begin
        rs_result_q <= alu_result;
        rs_tag_q    <= alu_rtag;
        rs_error_q  <= alu_error;
      end
    end
  end

  assign alu_start = (state_q == OP);
  assign alu_op    = alu_op_q;
  assign alu_data  = alu_data_q;
  assign alu_tag   = alu_tag_q;
  assign rs_valid  = rs_valid_q;
  assign rs_result = rs_result_q;
  assign rs_tag    = rs_tag_q;
  assign rs_error  = rs_error_q;

endmodule

// File: tb/tb_epw22_issue_ctrl.sv
// tb_epw22_issue_ctrl
//   Scoreboard bench for epw22_issue_ctrl. The stimulus process runs a
//   transaction-level model (set of allocated tags, owner per tag, issue
//   spacing counter, preferred requester) and queues the grants, ALU commands
//   and routed responses it expects; a negedge monitor pops and compares them
//   whenever the DUT presents one.
module tb_epw22_issue_ctrl;

  localparam int OP_W   = 4;
  localparam int DATA_W = 16;
  localparam int RES_W  = 32;
  localparam int TAG_W  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [1:0]          rq_valid = '0;
  logic [1:0]          rq_ready;
  logic [2*OP_W-1:0]   rq_op = '0;
  logic [2*DATA_W-1:0] rq_a = '0;
  logic [2*DATA_W-1:0] rq_b = '0;
  logic                alu_ready = 1'b0;
  logic                alu_start;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_data;
  logic [TAG_W-1:0]    alu_tag;
  logic                alu_valid = 1'b0;
  logic [RES_W-1:0]    alu_result = '0;
  logic [TAG_W-1:0]    alu_rtag = '0;
  logic                alu_error = 1'b0;
  logic [1:0]          rs_valid;
  logic [RES_W-1:0]    rs_result;
  logic [TAG_W-1:0]    rs_tag;
  logic                rs_error;
  logic [TAG_W:0]      outstanding;
  logic                proto_err;

  always #5 clk = ~clk;

  epw22_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rq_valid   (rq_valid),
    .rq_ready   (rq_ready),
    .rq_op      (rq_op),
    .rq_a       (rq_a),
    .rq_b       (rq_b),
    .alu_ready  (alu_ready),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_data   (alu_data),
    .alu_tag    (alu_tag),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .alu_rtag   (alu_rtag),
    .alu_error  (alu_error),
    .rs_valid   (rs_valid),
    .rs_result  (rs_result),
    .rs_tag     (rs_tag),
    .rs_error   (rs_error),
    .outstanding(outstanding),
    .proto_err  (proto_err)
  );

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [1:0] ready;
  } grant_t;

  typedef struct {
    int          cyc;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  tag;
  } issue_t;

  typedef struct {
    int          cyc;
    logic [1:0]  valid;
    logic [31:0] result;
    logic [1:0]  tag;
    logic        err;
  } resp_t;

  grant_t grantQ[$];
  issue_t issueQ[$];
  resp_t  respQ[$];

  logic [3:0]  opS[2];
  logic [15:0] aS[2];
  logic [15:0] bS[2];

  // Reference model state
  bit mAlloc[4];
  bit mOwner[4];
  bit mPref;
  int mBusy;
  bit mProto;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int modelOutstanding();
    int n = 0;
    foreach (mAlloc[i]) n += int'(mAlloc[i]);
    return n;
  endfunction

  task automatic clearModel();
    foreach (mAlloc[i]) begin
      mAlloc[i] = 1'b0;
      mOwner[i] = 1'b0;
    end
    mPref  = 1'b0;
    mBusy  = 0;
    mProto = 1'b0;
  endtask

  task automatic randomizeOperands();
    for (int r = 0; r < 2; r++) begin
      opS[r] = 4'($urandom);
      aS[r]  = 16'($urandom);
      bS[r]  = 16'($urandom);
    end
  endtask

  task automatic checkAllZero(input string when);
    checkOutput({when, " rq_ready"},    64'(rq_ready),    64'd0);
    checkOutput({when, " alu_start"},   64'(alu_start),   64'd0);
    checkOutput({when, " alu_op"},      64'(alu_op),      64'd0);
    checkOutput({when, " alu_data"},    64'(alu_data),    64'd0);
    checkOutput({when, " alu_tag"},     64'(alu_tag),     64'd0);
    checkOutput({when, " rs_valid"},    64'(rs_valid),    64'd0);
    checkOutput({when, " rs_result"},   64'(rs_result),   64'd0);
    checkOutput({when, " rs_tag"},      64'(rs_tag),      64'd0);
    checkOutput({when, " rs_error"},    64'(rs_error),    64'd0);
    checkOutput({when, " outstanding"}, 64'(outstanding), 64'd0);
    checkOutput({when, " proto_err"},   64'(proto_err),   64'd0);
  endtask

  // One clock cycle: check the counters, drive the inputs, advance the model.
  task automatic applyStimulus(input logic [1:0] v, input logic rdy, input logic rv,
                               input logic [1:0] rt, input logic [31:0] res, input logic re);
    int  lowest;
    bit  grant;
    bit  w;
    @(posedge clk);
    #1;
    checkOutput("outstanding", 64'(outstanding), 64'(modelOutstanding()));
    checkOutput("proto_err",   64'(proto_err),   64'(mProto));
    rq_valid   = v;
    alu_ready  = rdy;
    rq_op      = {opS[1], opS[0]};
    rq_a       = {aS[1], aS[0]};
    rq_b       = {bS[1], bS[0]};
    alu_valid  = rv;
    alu_rtag   = rt;
    alu_result = res;
    alu_error  = re;

    lowest = -1;
    for (int i = 0; i < 4; i++) if (!mAlloc[i] && lowest < 0) lowest = i;
    grant = (mBusy == 0) && (v != 2'b00) && (lowest >= 0) && rdy;
    if (mBusy > 0) mBusy--;
    w = 1'b0;
    if (grant) begin
      w     = (v == 2'b11) ? mPref : v[1];
      mPref = ~w;
      mBusy = 2;
      grantQ.push_back('{cycleCnt, (w ? 2'b10 : 2'b01)});
      issueQ.push_back('{cycleCnt + 1, opS[w], aS[w], bS[w], 2'(lowest)});
    end
    if (rv) begin
      if (mAlloc[rt]) begin
        respQ.push_back('{cycleCnt + 1, (mOwner[rt] ? 2'b10 : 2'b01), res, rt, re});
        mAlloc[rt] = 1'b0;
      end else begin
        mProto = 1'b1;
      end
    end
    if (grant) begin
      mAlloc[lowest] = 1'b1;
      mOwner[lowest] = w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
  endtask

  task automatic ret(input logic [1:0] t, input logic [31:0] res, input logic err);
    applyStimulus(2'b00, 1'b1, 1'b1, t, res, err);
  endtask

  task automatic checkDrained(input string when);
    checkOutput({when, " grant queue"}, 64'(grantQ.size()), 64'd0);
    checkOutput({when, " issue queue"}, 64'(issueQ.size()), 64'd0);
    checkOutput({when, " resp queue"},  64'(respQ.size()),  64'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin : monitor
    grant_t g;
    issue_t is;
    resp_t  r;
    static bit          bPending = 1'b0;
    static logic [15:0] bExp = '0;
    if (!reset) begin
      grantQ.delete();
      issueQ.delete();
      respQ.delete();
      bPending = 1'b0;
    end else begin
      if (bPending) begin
        checkOutput("alu_data B", 64'(alu_data), 64'(bExp));
        bPending = 1'b0;
      end
      if (rq_ready != 2'b00) begin
        if (grantQ.size() == 0) begin
          checkOutput("unexpected rq_ready", 64'(rq_ready), 64'd0);
        end else begin
          g = grantQ.pop_front();
          checkOutput("rq_ready", 64'(rq_ready), 64'(g.ready));
          checkOutput("grant cycle", 64'(cycleCnt), 64'(g.cyc));
        end
      end
      if (alu_start) begin
        if (issueQ.size() == 0) begin
          checkOutput("unexpected alu_start", 64'(alu_start), 64'd0);
        end else begin
          is = issueQ.pop_front();
          checkOutput("alu_start cycle", 64'(cycleCnt), 64'(is.cyc));
          checkOutput("alu_op",     64'(alu_op),   64'(is.op));
          checkOutput("alu_data A", 64'(alu_data), 64'(is.a));
          checkOutput("alu_tag",    64'(alu_tag),  64'(is.tag));
          bPending = 1'b1;
          bExp     = is.b;
        end
      end
      if (rs_valid != 2'b00) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected rs_valid", 64'(rs_valid), 64'd0);
        end else begin
          r = respQ.pop_front();
          checkOutput("rs cycle",  64'(cycleCnt),  64'(r.cyc));
          checkOutput("rs_valid",  64'(rs_valid),  64'(r.valid));
          checkOutput("rs_result", 64'(rs_result), 64'(r.result));
          checkOutput("rs_tag",    64'(rs_tag),    64'(r.tag));
          checkOutput("rs_error",  64'(rs_error),  64'(r.err));
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0] v;
    logic       rdy;
    logic       rv;
    logic [1:0] rt;
    int         cand[$];

    clearModel();
    for (int r = 0; r < 2; r++) begin
      opS[r] = '0;
      aS[r]  = '0;
      bS[r]  = '0;
    end

    // Power-on reset with requests pending: everything must stay at zero.
    rq_valid  = 2'b11;
    alu_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset    = 1'b1;
    rq_valid = 2'b00;

    // Single issue from requester 0, then its result on tag 0.
    opS[0] = 4'd3;
    aS[0]  = 16'h0005;
    bS[0]  = 16'h0007;
    applyStimulus(2'b01, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    idle(3);
    ret(2'd0, 32'd12, 1'b0);
    idle(2);
    checkDrained("single issue");

    // Round robin with both requesters asking until all tags are taken,
    // then several stalled cycles while the pool is full.
    randomizeOperands();
    for (int i = 0; i < 15; i++) applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    checkOutput("pool full", 64'(outstanding), 64'd4);
    ret(2'd2, 32'h0000_1234, 1'b0);
    ret(2'd0, 32'h0000_5678, 1'b0);
    randomizeOperands();
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    idle(2);
    ret(2'd1, 32'hAAAA_0001, 1'b0);
    ret(2'd3, 32'hAAAA_0003, 1'b0);
    ret(2'd0, 32'hAAAA_0000, 1'b0);
    ret(2'd2, 32'hDEAD_BEEF, 1'b1);
    idle(2);
    checkDrained("round robin");

    // ALU backpressure: requester 1 waits until alu_ready rises.
    randomizeOperands();
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    idle(3);
    ret(2'd0, 32'h0BAD_F00D, 1'b1);
    idle(2);
    checkDrained("backpressure");

    // Randomised traffic, returns chosen from the model's allocated tags.
    for (int c = 0; c < 400; c++) begin
      randomizeOperands();
      v   = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      rv  = 1'b0;
      rt  = 2'd0;
      cand.delete();
      for (int i = 0; i < 4; i++) if (mAlloc[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
        rv = 1'b1;
        rt = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      applyStimulus(v, rdy, rv, rt, $urandom, 1'($urandom_range(0, 1)));
    end

    // Drain every outstanding tag.
    for (int k = 0; k < 8 && modelOutstanding() > 0; k++) begin
      rt = 2'd0;
      for (int i = 3; i >= 0; i--) if (mAlloc[i]) rt = 2'(i);
      ret(rt, $urandom, 1'b0);
    end
    idle(3);
    checkDrained("random");

    // Result on a free tag: no response, proto_err sticks.
    ret(2'd3, 32'h1111_2222, 1'b0);
    idle(4);
    checkOutput("proto_err sticky", 64'(proto_err), 64'd1);
    checkDrained("proto error");

    // Reset while a command is in its DATA cycle.
    randomizeOperands();
    applyStimulus(2'b01, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    checkOutput("alu_data before reset", 64'(alu_data), 64'(bS[0]));
    reset     = 1'b0;
    rq_valid  = 2'b11;
    alu_ready = 1'b1;
    clearModel();
    #1;
    checkAllZero("mid reset");
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    rq_valid = 2'b00;
    randomizeOperands();
    applyStimulus(2'b01, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    idle(3);
    ret(2'd0, 32'h0000_00FF, 1'b0);
    idle(3);
    checkDrained("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
